// File: rtl/nios2_mem_arbiter.sv
// Two-master arbiter in front of a single-port on-chip memory.
// m0 (CPU data) has fixed priority; m1 (debug/loader) is forced a grant after
// m0 has won STARVE_LIMIT contested cycles in a row. Writes reach the memory
// only with debugaccess set; blocked writes are still accepted and flagged on
// prot_err one cycle later. Read data returns one cycle after the grant.
module nios2_mem_arbiter #(
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned BE_W         = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              freeze,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic              m0_debugaccess,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic              m1_debugaccess,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_debugaccess,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,

    output logic              prot_err
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_M0,
        OWN_M1
    } owner_e;

    owner_e     owner;
    logic       req0, req1;
    logic       win_write, win_debug;
    logic [3:0] starve_q, starve_d;
    logic       rd_pend0_q, rd_pend0_d;
    logic       rd_pend1_q, rd_pend1_d;
    logic       prot_err_q, prot_err_d;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Same-cycle grant: fixed m0 priority, m1 forced once the starvation count hits the limit
    always_comb begin
        owner = OWN_NONE;
        if (!reset && !freeze) begin
            if (req0 && req1) begin
                owner = (starve_q == LIMIT) ? OWN_M1 : OWN_M0;
            end else if (req0) begin
                owner = OWN_M0;
            end else if (req1) begin
                owner = OWN_M1;
            end
        end
    end

    // Route the winner's command to the memory port; idle port drives all zeros
    always_comb begin
        mem_address     = '0;
        mem_byteenable  = '0;
        mem_writedata   = '0;
        mem_debugaccess = 1'b0;
        mem_chipselect  = 1'b0;
        win_write       = 1'b0;
        win_debug       = 1'b0;
        unique case (owner)
            OWN_M0: begin
                mem_address     = m0_address;
                mem_byteenable  = m0_byteenable;
                mem_writedata   = m0_writedata;
                mem_debugaccess = m0_debugaccess;
                mem_chipselect  = 1'b1;
                win_write       = m0_write;
                win_debug       = m0_debugaccess;
            end
            OWN_M1: begin
                mem_address     = m1_address;
                mem_byteenable  = m1_byteenable;
                mem_writedata   = m1_writedata;
                mem_debugaccess = m1_debugaccess;
                mem_chipselect  = 1'b1;
                win_write       = m1_write;
                win_debug       = m1_debugaccess;
            end
            default: ;
        endcase
        mem_write = win_write & win_debug;
    end

    // Next-state for starvation count, read-pending flags and protection error
    always_comb begin
        if (owner == OWN_M1 || !req1) begin
            starve_d = '0;
        end else if (owner == OWN_M0 && starve_q < LIMIT) begin
            starve_d = starve_q + 4'd1;
        end else begin
            starve_d = starve_q;
        end
        // read and write together counts as a write, so no data phase follows
        rd_pend0_d = (owner == OWN_M0) && m0_read && !m0_write;
        rd_pend1_d = (owner == OWN_M1) && m1_read && !m1_write;
        prot_err_d = (owner != OWN_NONE) && win_write && !win_debug;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q   <= '0;
            rd_pend0_q <= 1'b0;
            rd_pend1_q <= 1'b0;
            prot_err_q <= 1'b0;
        end else begin
            starve_q   <= starve_d;
            rd_pend0_q <= rd_pend0_d;
            rd_pend1_q <= rd_pend1_d;
            prot_err_q <= prot_err_d;
        end
    end

    assign m0_waitrequest = (owner != OWN_M0);
    assign m1_waitrequest = (owner != OWN_M1);

    // Reset arriving the cycle after a grant must hide the still-set pending flag
    assign m0_readdatavalid = rd_pend0_q & ~reset;
    assign m1_readdatavalid = rd_pend1_q & ~reset;
    assign prot_err         = prot_err_q & ~reset;

    assign m0_readdata = mem_readdata;
    assign m1_readdata = mem_readdata;
    assign mem_clken   = 1'b1;

endmodule

// File: doc/nios2_mem_arbiter.md
Name: nios2_mem_arbiter

Overview:
- Shares one single-port on-chip memory (32 x 16-bit, byte-enabled, 1-cycle read latency) between two Avalon-MM masters.
  - m0: CPU data master, high priority.
  - m1: debug/loader master, low priority.
- Issues at most one access per cycle, with fixed priority plus a starvation guard.
- Enforces write protection: memory writes happen only when debugaccess is asserted.
- Sits between the interconnect and the memory macro's slave port.

Parameters:
- ADDR_W, 5, word address width.
- DATA_W, 16, data width.
- BE_W, 2, byteenable width (DATA_W/8).
- STARVE_LIMIT, 4, consecutive contested cycles m0 may win before m1 is forced a grant (range 1..15).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- freeze  in  1  when high, no new grants are issued.
- m0_address  in  ADDR_W  m0 word address.
- m0_byteenable  in  BE_W  m0 byte lanes.
- m0_read  in  1  m0 read request.
- m0_write  in  1  m0 write request.
- m0_writedata  in  DATA_W  m0 write data.
- m0_debugaccess  in  1  m0 write permission.
- m0_waitrequest  out  1  low = m0 access accepted this cycle.
- m0_readdata  out  DATA_W  m0 read data.
- m0_readdatavalid  out  1  m0 read data valid.
- m1_* : the same nine ports as m0_*, for m1.
- mem_address  out  ADDR_W  to memory.
- mem_byteenable  out  BE_W  to memory.
- mem_chipselect  out  1  to memory.
- mem_write  out  1  to memory.
- mem_writedata  out  DATA_W  to memory.
- mem_debugaccess  out  1  to memory.
- mem_clken  out  1  memory clock enable, constant 1.
- mem_readdata  in  DATA_W  from memory, valid 1 cycle after issue.
- prot_err  out  1  one-cycle pulse on a blocked write.

Behaviour:
- Request: reqX = mX_read | mX_write. If both are asserted, the access is treated as a write.
- Grant (combinational, same cycle):
  - No grant when reset or freeze is high.
  - Otherwise, with one requester, that requester wins.
  - With both requesting, m0 wins unless starve_cnt == STARVE_LIMIT, in which case m1 wins.
- starve_cnt (4-bit register):
  - Increments when both request and m0 wins.
  - Clears when m1 is granted or m1 is not requesting.
  - Saturates at STARVE_LIMIT.
- Waitrequest: mX_waitrequest = ~grantX. Both are 1 during reset and during freeze.
- Memory drive:
  - With a grant, mem_address, byteenable, writedata and debugaccess come from the winner; mem_chipselect = 1.
  - With no grant, mem_chipselect = 0 and the other mem_* outputs are 0.
  - mem_write = winner write & winner debugaccess.
- Protected write (write with debugaccess = 0):
  - Accepted: waitrequest is 0, so the master is not stalled.
  - Memory is untouched.
  - prot_err pulses 1 in the cycle after the grant.
- Reads:
  - rd_pend_X register is set at the end of a granted read cycle.
  - mX_readdatavalid = rd_pend_X, asserted exactly 1 cycle after the grant.
  - mX_readdata = mem_readdata, passed through. Its value is don't-care when valid is 0.
  - Back-to-back reads are fully pipelined, one per cycle, in order.
  - m0 and m1 valids never assert in the same cycle.
- Writes produce no readdatavalid.
- Freeze asserted while a read is pending: the pending valid still asserts on the next cycle.
- Reset values:
  - starve_cnt = 0, rd_pend_0/1 = 0, prot_err = 0.
  - Both waitrequests = 1; all mem_* outputs = 0 except mem_clken = 1.
- Reset asserted the cycle after a read grant: the pending readdatavalid is suppressed (0).
- Address wrap: none. The address is passed through; all 2^ADDR_W words are legal.

Test Plan:
- Single m0 read of addr 5 (memory word 5 = 0x1234):
  - Cycle 0: m0_waitrequest = 0, mem_address = 5, mem_chipselect = 1.
  - Cycle 1: m0_readdatavalid = 1, m0_readdata = 0x1234.
- m1 write addr 3, data 0xBEEF, be = 2'b11, debugaccess = 1 -> mem_write = 1 for one cycle; a later m1 read of addr 3 returns 0xBEEF.
- m0 write addr 3, data 0x0000, debugaccess = 0:
  - Accepted: m0_waitrequest = 0, mem_write = 0.
  - prot_err = 1 on the next cycle; a read of addr 3 still returns 0xBEEF.
- m0 and m1 request reads continuously, STARVE_LIMIT = 4:
  - Grant pattern is m0 x4 then m1 x1, repeating.
  - Every read gets exactly one readdatavalid to the correct master, 1 cycle later, in order.
- freeze = 1 with both requesting -> both waitrequest = 1, mem_chipselect = 0, starve_cnt unchanged. A read granted the cycle before freeze still returns valid.
- m0 read granted at cycle 0, reset = 1 at cycle 1:
  - m0_readdatavalid stays 0.
  - Both waitrequests = 1; starve_cnt = 0.
  - After reset release, a read of addr 0 completes normally.
